fir_tap_multiplier: RTL and testbench

- Front end of the parallel FIR datapath: accepts Q1.15 input samples, keeps them in a TAPS-deep delay line, and multiplies every tap by its programmable Q1.15 coefficient.
- Presents the full registered product array with a one-cycle valid pulse. This is the producer for the adder-tree accumulator's multiplier_out/in_valid interface.
- Coefficients are loaded serially at runtime. Samples are only accepted once a full coefficient set is loaded.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_coef_bank.sv | 81 ++++++++
 rtl/fir_tap_multiplier.sv | 90 +++++++++
 tb/tb_fir_tap_multiplier.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap-multiplier front end.
// SYMMETRIC_COEF_EN selects half-length symmetric coefficient loading.
package fir_pkg;

    localparam int DATABITS_DEF = 16;
    localparam int MULTBITS_DEF = 32;
    localparam int QSHIFT       = 15;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } fir_state_e;

    function automatic int ncoef(input int taps);
`ifdef SYMMETRIC_COEF_EN
        return (taps + 1) / 2;
`else
        return taps;
`endif
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Serially loaded coefficient register file with LOAD/RUN state.
// SYMMETRIC_COEF_EN stores ceil(TAPS/2) and mirrors the upper half.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int TAPS     = 401,
    parameter int DATABITS = DATABITS_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coef_clear,
    input  logic                       coef_wr_en,
    input  logic signed [DATABITS-1:0] coef_wr_data,
    output logic signed [DATABITS-1:0] coef [0:TAPS-1],
    output logic                       coef_loaded
);

    localparam int NCOEF = ncoef(TAPS);
    localparam int PTRW  = $clog2(NCOEF + 1);

    logic signed [DATABITS-1:0] coef_q [0:NCOEF-1];
    logic signed [DATABITS-1:0] coef_d [0:NCOEF-1];
    logic [PTRW-1:0]            ptr_q, ptr_d;
    fir_state_e                 state_q, state_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        coef_d  = coef_q;
        if (coef_clear) begin
            // Clear wins over a same-cycle write; stored values are kept.
            state_d = LOAD;
            ptr_d   = '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (coef_wr_en) begin
                        for (int k = 0; k < NCOEF; k++) begin
                            if (ptr_q == PTRW'(k)) begin
                                coef_d[k] = coef_wr_data;
                            end
                        end
                        if (ptr_q == PTRW'(NCOEF - 1)) begin
                            state_d = RUN;
                            ptr_d   = '0;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
                RUN:     ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            ptr_q   <= '0;
            for (int k = 0; k < NCOEF; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            coef_q  <= coef_d;
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_map
        if (k < NCOEF) begin : g_direct
            assign coef[k] = coef_q[k];
        end else begin : g_mirror
            assign coef[k] = coef_q[TAPS-1-k];
        end
    end

    assign coef_loaded = (state_q == RUN);

endmodule

// File: rtl/fir_tap_multiplier.sv
// FIR front end: sample delay line and registered per-tap products.
// SYMMETRIC_COEF_EN (see fir_pkg) halves the coefficient load.
module fir_tap_multiplier
    import fir_pkg::*;
#(
    parameter int TAPS     = 401,
    parameter int DATABITS = DATABITS_DEF,
    parameter int MULTBITS = MULTBITS_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [DATABITS-1:0] sample_in,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic                       coef_clear,
    input  logic                       coef_wr_en,
    input  logic signed [DATABITS-1:0] coef_wr_data,
    output logic                       coef_loaded,
    output logic signed [MULTBITS-1:0] multiplier_out [0:TAPS-1],
    output logic                       prod_valid
);

    logic signed [DATABITS-1:0] coef   [0:TAPS-1];
    logic signed [DATABITS-1:0] tap_q  [0:TAPS-1];
    logic signed [DATABITS-1:0] tap_d  [0:TAPS-1];
    logic signed [MULTBITS-1:0] prod_q [0:TAPS-1];
    logic signed [MULTBITS-1:0] prod_d [0:TAPS-1];
    logic                       acc_q, acc_d;
    logic                       vld_q, vld_d;
    logic                       accept;

    fir_coef_bank #(
        .TAPS     (TAPS),
        .DATABITS (DATABITS)
    ) u_bank (
        .clk          (clk),
        .rst_n        (rst_n),
        .coef_clear   (coef_clear),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_data (coef_wr_data),
        .coef         (coef),
        .coef_loaded  (coef_loaded)
    );

    assign sample_ready = coef_loaded & ~coef_clear;
    assign accept       = sample_valid & sample_ready;

    always_comb begin
        tap_d  = tap_q;
        prod_d = prod_q;
        acc_d  = accept;
        vld_d  = acc_q;
        if (coef_clear) begin
            for (int k = 0; k < TAPS; k++) begin
                tap_d[k] = '0;
            end
        end else if (accept) begin
            tap_d[0] = sample_in;
            for (int k = 1; k < TAPS; k++) begin
                tap_d[k] = tap_q[k-1];
            end
        end
        // Products follow the delay-line update by one edge.
        if (acc_q) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_d[k] = MULTBITS'(tap_q[k]) * MULTBITS'(coef[k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
            vld_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                tap_q[k]  <= '0;
                prod_q[k] <= '0;
            end
        end else begin
            acc_q  <= acc_d;
            vld_q  <= vld_d;
            tap_q  <= tap_d;
            prod_q <= prod_d;
        end
    end

    assign multiplier_out = prod_q;
    assign prod_valid     = vld_q;

endmodule

// File: tb/tb_fir_tap_multiplier.sv
// Directed self-checking bench for fir_tap_multiplier (TAPS=4).
// Targets the default build with full-length coefficient loading.
module tb_fir_tap_multiplier;

    localparam int TAPS = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic               sample_valid = 1'b0;
    logic               sample_ready;
    logic               coef_clear = 1'b0;
    logic               coef_wr_en = 1'b0;
    logic signed [15:0] coef_wr_data = '0;
    logic               coef_loaded;
    logic signed [31:0] mo [0:TAPS-1];
    logic               prod_valid;

    int checks = 0;
    int failures = 0;
    int pulses;

    fir_tap_multiplier #(
        .TAPS     (TAPS),
        .DATABITS (16),
        .MULTBITS (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .coef_clear     (coef_clear),
        .coef_wr_en     (coef_wr_en),
        .coef_wr_data   (coef_wr_data),
        .coef_loaded    (coef_loaded),
        .multiplier_out (mo),
        .prod_valid     (prod_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3);
        chk({tag, "[0]"}, mo[0], e0);
        chk({tag, "[1]"}, mo[1], e1);
        chk({tag, "[2]"}, mo[2], e2);
        chk({tag, "[3]"}, mo[3], e3);
    endtask

    task automatic load4(input logic [15:0] c0, input logic [15:0] c1,
                         input logic [15:0] c2, input logic [15:0] c3);
        logic [15:0] cs [0:3];
        cs = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            coef_wr_en   = 1'b1;
            coef_wr_data = cs[i];
            step();
            if (i == 2) begin
                chk("ready_after_3_writes", 32'(sample_ready), 32'd0);
            end
        end
        coef_wr_en = 1'b0;
        chk("loaded_after_4", 32'(coef_loaded), 32'd1);
        chk("ready_after_4", 32'(sample_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_ready", 32'(sample_ready), 32'd0);
        chk("rst_loaded", 32'(coef_loaded), 32'd0);
        chk("rst_valid", 32'(prod_valid), 32'd0);
        chk_out("rst_out", 32'h0, 32'h0, 32'h0, 32'h0);

        rst_n        = 1'b1;
        sample_valid = 1'b1;
        step();
        chk("ready_unloaded", 32'(sample_ready), 32'd0);
        sample_valid = 1'b0;

        // Impulse response through coefficients {0.5, 0.25, -0.5, ~1}
        load4(16'h4000, 16'h2000, 16'hC000, 16'h7FFF);
        sample_valid = 1'b1;
        sample_in    = 16'sh7FFF;
        step();
        chk("imp_valid_e1", 32'(prod_valid), 32'd0);
        sample_in = '0;
        step();
        chk("imp_valid_e2", 32'(prod_valid), 32'd1);
        chk_out("imp_e2", 32'h1FFFC000, 32'h0, 32'h0, 32'h0);
        step();
        chk_out("imp_e3", 32'h0, 32'h0FFFE000, 32'h0, 32'h0);
        step();
        chk_out("imp_e4", 32'h0, 32'h0, 32'hE0004000, 32'h0);
        sample_valid = 1'b0;
        step();
        chk("imp_valid_e5", 32'(prod_valid), 32'd1);
        chk_out("imp_e5", 32'h0, 32'h0, 32'h0, 32'h3FFF0001);
        step();
        chk("imp_idle_valid", 32'(prod_valid), 32'd0);
        chk("imp_hold3", mo[3], 32'h3FFF0001);

        // Throughput: 10 back-to-back accepts
        pulses       = 0;
        sample_valid = 1'b1;
        sample_in    = 16'sh1000;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 10) sample_valid = 1'b0;
            chk("tput_valid", 32'(prod_valid),
                32'((e >= 2) && (e <= 11)));
            if (prod_valid) pulses++;
        end
        chk("tput_pulses", 32'(pulses), 32'd10);
        chk_out("tput_out", 32'h04000000, 32'h02000000,
                32'hFC000000, 32'h07FFF000);

        // Clear in RUN with a sample offered
        coef_clear   = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 16'sh2000;
        #1;
        chk("clr_ready", 32'(sample_ready), 32'd0);
        step();
        coef_clear   = 1'b0;
        #1;
        chk("clr_loaded", 32'(coef_loaded), 32'd0);
        chk("clr_ready_after", 32'(sample_ready), 32'd0);
        step();
        chk("clr_no_valid", 32'(prod_valid), 32'd0);
        sample_valid = 1'b0;

        // Reload with -1.0 everywhere; extremes and zeroed delay line
        load4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        sample_valid = 1'b1;
        sample_in    = 16'sh8000;
        step();
        step();
        chk_out("ext_first", 32'h40000000, 32'h0, 32'h0, 32'h0);
        step();
        step();
        sample_valid = 1'b0;
        step();
        chk("ext_valid", 32'(prod_valid), 32'd1);
        chk_out("ext_full", 32'h40000000, 32'h40000000,
                32'h40000000, 32'h40000000);

        // Asynchronous reset mid-stream
        sample_valid = 1'b1;
        sample_in    = 16'sh1234;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(prod_valid), 32'd0);
        chk("arst_loaded", 32'(coef_loaded), 32'd0);
        chk("arst_ready", 32'(sample_ready), 32'd0);
        chk_out("arst_out", 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_ready_after", 32'(sample_ready), 32'd0);
        step();
        chk("arst_no_valid", 32'(prod_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
